// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU constants, result-entry type and operand classifier.
// Revision    : 1.0
// ============================================================================
package fpu_pkg;

    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam int          FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] result;
        logic        invalid;
        logic        ovf;
    } fpu_entry_t;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    // Denormals report as zero: the datapath flushes them.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.is_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
        c.is_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
        c.is_zero = (x[30:23] == 8'h00);
        return c;
    endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_sp_special_case_fixup.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sp_special_case_fixup
// Description : Combinational IEEE-754 special-case correction for a - b.
// Revision    : 1.0
// ============================================================================
module fpu_sp_special_case_fixup
    import fpu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_raw_result,
    input  logic        i_raw_ovf,
    output logic [31:0] o_result,
    output logic        o_invalid,
    output logic        o_ovf
);

    fp_class_t w_ca;
    fp_class_t w_cb;
    logic [31:0] w_neg_b;

    assign w_ca    = classify(i_a);
    assign w_cb    = classify(i_b);
    assign w_neg_b = {~i_b[31], i_b[30:0]};

    // First matching rule wins; only the pass-through case keeps the raw ovf.
    always_comb begin
        o_result  = i_raw_result;
        o_invalid = 1'b0;
        o_ovf     = 1'b0;
        if (w_ca.is_nan || w_cb.is_nan) begin
            o_result  = QNAN;
            o_invalid = 1'b1;
        end else if (w_ca.is_inf && w_cb.is_inf && (i_a[31] == i_b[31])) begin
            o_result  = QNAN;
            o_invalid = 1'b1;
        end else if (w_ca.is_inf) begin
            o_result = i_a;
        end else if (w_cb.is_inf) begin
            o_result = w_neg_b;
        end else if (w_ca.is_zero && w_cb.is_zero) begin
            o_result = {i_a[31] & ~i_b[31], 31'd0};
        end else if (w_cb.is_zero) begin
            o_result = i_a;
        end else if (w_ca.is_zero) begin
            o_result = w_neg_b;
        end else if (i_a == i_b) begin
            o_result = 32'h00000000;
        end else begin
            o_result = i_raw_result;
            o_ovf    = i_raw_ovf;
        end
    end

endmodule : fpu_sp_special_case_fixup
`default_nettype wire

// File: rtl/fpu_sp_sub_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sp_sub_result_stage
// Description : Subtractor result stage: special-case fixup, 2-entry output
//               FIFO, sticky exception flags and completed-operation counter.
// Revision    : 1.0
// ============================================================================
module fpu_sp_sub_result_stage
    import fpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic [31:0]          in_result,
    input  logic                 in_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_invalid,
    output logic                 out_ovf,
    input  logic                 clear_flags,
    output logic                 sticky_invalid,
    output logic                 sticky_ovf,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_OCC_W-1:0] c_FULL_OCC = c_OCC_W'(FIFO_DEPTH);

    fpu_entry_t          w_entry;
    fpu_entry_t          w_head;
    fpu_entry_t          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_OCC_W-1:0]  r_count;
    logic                r_sticky_invalid;
    logic                r_sticky_ovf;
    logic [CNT_WIDTH-1:0] r_op_count;
    logic                w_push;
    logic                w_pop;

    fpu_sp_special_case_fixup u_fixup (
        .i_a          (in_a),
        .i_b          (in_b),
        .i_raw_result (in_result),
        .i_raw_ovf    (in_ovf),
        .o_result     (w_entry.result),
        .o_invalid    (w_entry.invalid),
        .o_ovf        (w_entry.ovf)
    );

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign in_ready  = (r_count < c_FULL_OCC);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Empty FIFO presents all-zero outputs rather than stale storage.
    assign w_head      = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_result  = w_head.result;
    assign out_invalid = w_head.invalid;
    assign out_ovf     = w_head.ovf;

    assign sticky_invalid = r_sticky_invalid;
    assign sticky_ovf     = r_sticky_ovf;
    assign op_count       = r_op_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_op_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr   <= next_ptr(r_rd_ptr);
                r_op_count <= r_op_count + CNT_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_W'(1);
                2'b01:   r_count <= r_count - c_OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A push that sets a flag beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_invalid <= 1'b0;
            r_sticky_ovf     <= 1'b0;
        end else begin
            r_sticky_invalid <= (r_sticky_invalid & ~clear_flags) | (w_push & w_entry.invalid);
            r_sticky_ovf     <= (r_sticky_ovf & ~clear_flags) | (w_push & w_entry.ovf);
        end
    end

endmodule : fpu_sp_sub_result_stage
`default_nettype wire

// File: tb/tb_fpu_sp_sub_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_sp_sub_result_stage
// Description : Directed vector bench for the subtractor result stage.
// Revision    : 1.0
// ============================================================================
module tb_fpu_sp_sub_result_stage;

    localparam int CNT_WIDTH = 4;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_a;
    logic [31:0]          in_b;
    logic [31:0]          in_result;
    logic                 in_ovf;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic                 out_invalid;
    logic                 out_ovf;
    logic                 clear_flags;
    logic                 sticky_invalid;
    logic                 sticky_ovf;
    logic [CNT_WIDTH-1:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_WIDTH-1:0] exp_cnt;

    fpu_sp_sub_result_stage #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_result      (in_result),
        .in_ovf         (in_ovf),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_invalid    (out_invalid),
        .out_ovf        (out_ovf),
        .clear_flags    (clear_flags),
        .sticky_invalid (sticky_invalid),
        .sticky_ovf     (sticky_ovf),
        .op_count       (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic [31:0] exp_res;
        logic        exp_inv;
        logic        exp_ovf;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic o);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_result = r;
        in_ovf    = o;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0, 32'h3F000000, 1'b0, 1'b0};
        vecs[1]  = '{32'h7F800000, 32'h7F800000, 32'h11111111, 1'b1, 32'h7FC00000, 1'b1, 1'b0};
        vecs[2]  = '{32'h80000000, 32'h00000000, 32'h22222222, 1'b0, 32'h80000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h40490FDB, 32'h40490FDB, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h3F800000, 32'h33333333, 1'b0, 32'hBF800000, 1'b0, 1'b0};
        vecs[5]  = '{32'h7F800001, 32'h3F800000, 32'h44444444, 1'b0, 32'h7FC00000, 1'b1, 1'b0};
        vecs[6]  = '{32'h3F800000, 32'hFFC00000, 32'h55555555, 1'b0, 32'h7FC00000, 1'b1, 1'b0};
        vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h66666666, 1'b1, 32'h7F800000, 1'b0, 1'b0};
        vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'h77777777, 1'b0, 32'hFF800000, 1'b0, 1'b0};
        vecs[9]  = '{32'h40000000, 32'h00000001, 32'h01020304, 1'b0, 32'h40000000, 1'b0, 1'b0};
        vecs[10] = '{32'h80000005, 32'hC0400000, 32'h0A0B0C0D, 1'b0, 32'h40400000, 1'b0, 1'b0};
        vecs[11] = '{32'h7F000000, 32'hFF000000, 32'h7F800000, 1'b1, 32'h7F800000, 1'b0, 1'b1};
        vecs[12] = '{32'h00000000, 32'h80000000, 32'h0F0F0F0F, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[13] = '{32'h80000000, 32'h80000000, 32'hF0F0F0F0, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[14] = '{32'hFF800000, 32'hFF800000, 32'h13579BDF, 1'b0, 32'h7FC00000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_result = '0;
        in_ovf = 1'b0; out_ready = 1'b0; clear_flags = 1'b0; exp_cnt = '0;
        step();
        do_reset();

        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_result", out_result, 32'd0);
        check("rst_sticky", {30'd0, sticky_invalid, sticky_ovf}, 32'd0);
        check("rst_op_count", {28'd0, op_count}, 32'd0);

        // Table: accept, check head one cycle later, pop.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_result", i), out_result, vecs[i].exp_res);
            check($sformatf("v%0d_flags", i), {30'd0, out_invalid, out_ovf},
                  {30'd0, vecs[i].exp_inv, vecs[i].exp_ovf});
            step();
            exp_cnt = exp_cnt + 1'b1;
            if (i == 1) check("inf_sticky_inv", {31'd0, sticky_invalid}, 32'd1);
        end
        check("tbl_empty", {31'd0, out_valid}, 32'd0);
        check("tbl_empty_result", out_result, 32'd0);
        check("tbl_op_count", {28'd0, op_count}, {28'd0, exp_cnt});
        check("tbl_sticky", {30'd0, sticky_invalid, sticky_ovf}, 32'd3);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("clear_sticky", {30'd0, sticky_invalid, sticky_ovf}, 32'd0);

        // Backpressure: third word refused, head stable, drain in order.
        do_reset();
        out_ready = 1'b0;
        drive(32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0);
        step();
        check("bp_ready1", {31'd0, in_ready}, 32'd1);
        check("bp_head1", out_result, 32'h3F000000);
        drive(32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0);
        step();
        check("bp_ready2", {31'd0, in_ready}, 32'd0);
        drive(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0);
        step();
        check("bp_ready3", {31'd0, in_ready}, 32'd0);
        check("bp_stable", out_result, 32'h3F000000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_pop1", out_result, 32'h3F800000);
        check("bp_pop1_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_pop2_valid", {31'd0, out_valid}, 32'd0);
        check("bp_op_count", {28'd0, op_count}, 32'd2);
        exp_cnt = 2;

        // Push+pop at occupancy 1, with clear racing an ovf push.
        out_ready = 1'b0;
        drive(32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0);
        step();
        drive(32'h7F000000, 32'hFF000000, 32'h7F800000, 1'b1);
        out_ready = 1'b1;
        clear_flags = 1'b1;
        step();
        exp_cnt = exp_cnt + 1'b1;
        in_valid = 1'b0;
        clear_flags = 1'b0;
        check("sim_valid", {31'd0, out_valid}, 32'd1);
        check("sim_next_head", out_result, 32'h7F800000);
        check("sim_head_ovf", {31'd0, out_ovf}, 32'd1);
        check("sim_sticky_ovf", {31'd0, sticky_ovf}, 32'd1);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("sim_occ1", {31'd0, out_valid}, 32'd0);

        // Counter wrap from all-ones.
        while (exp_cnt != '1) begin
            drive(32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0);
            step();
            in_valid = 1'b0;
            step();
            exp_cnt = exp_cnt + 1'b1;
        end
        check("cnt_max", {28'd0, op_count}, 32'd15);
        drive(32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        check("cnt_wrap", {28'd0, op_count}, 32'd0);

        // Reset with two stored entries and both flags set.
        out_ready = 1'b0;
        drive(32'h7F000000, 32'hFF000000, 32'h7F800000, 1'b1);
        step();
        drive(32'h7F800000, 32'h7F800000, 32'h0, 1'b0);
        step();
        check("mr_full", {30'd0, out_valid, in_ready}, 32'd2);
        check("mr_sticky", {30'd0, sticky_invalid, sticky_ovf}, 32'd3);
        drive(32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0);
        out_ready = 1'b1;
        clear_flags = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        clear_flags = 1'b0;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_sticky0", {30'd0, sticky_invalid, sticky_ovf}, 32'd0);
        check("mr_op_count", {28'd0, op_count}, 32'd0);
        check("mr_out_result", out_result, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fpu_sp_sub_result_stage
`default_nettype wire
